// File: rtl/fsk_pkg.sv
// Shared types and elaboration-time helpers for the FSK bit decider.
// Counts from the analyzer and the window timer share one width.
package fsk_pkg;

  localparam int COUNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPTURE,
    FLUSH
  } fsk_state_t;

  function automatic logic [COUNT_W-1:0] window_ticks(
    input logic [63:0] clock_hz,
    input logic [63:0] bit_rate
  );
    logic [63:0] ticks;
    ticks = clock_hz / bit_rate;
    return ticks[COUNT_W-1:0];
  endfunction

  // Product is formed in 64 bits so large clocks cannot overflow before the divide.
  function automatic logic [COUNT_W-1:0] occupancy_threshold(
    input logic [63:0] ticks,
    input logic [63:0] percent
  );
    logic [63:0] thresh;
    thresh = (ticks * percent) / 64'd100;
    return thresh[COUNT_W-1:0];
  endfunction

endpackage

// File: rtl/fsk_window_timer.sv
// Bit-window counter: advances on enabled cycles once the decider has left IDLE,
// wraps at WINDOW_TICKS-1 and flags that last cycle as the window end.
module fsk_window_timer
  import fsk_pkg::*;
#(
  parameter logic [COUNT_W-1:0] WINDOW_TICKS = 32'd50000
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  input  logic run,
  output logic window_end
);

  localparam logic [COUNT_W-1:0] LAST_TICK = WINDOW_TICKS - 32'd1;

  logic [COUNT_W-1:0] window_cnt_reg;
  logic [COUNT_W-1:0] window_cnt_next;
  logic               advance;

  assign advance    = enable & run;
  assign window_end = advance & (window_cnt_reg == LAST_TICK);

  always_comb begin
    window_cnt_next = window_cnt_reg;
    if (advance) begin
      window_cnt_next = window_end ? '0 : window_cnt_reg + COUNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      window_cnt_reg <= '0;
    end else begin
      window_cnt_reg <= window_cnt_next;
    end
  end

endmodule

// File: rtl/fsk_bit_decider.sv
// Samples the analyzer's tone counts at every bit-window end, decides the bit,
// pulses the analyzer clear and offers the bit through a one-entry valid/ready buffer.
module fsk_bit_decider
  import fsk_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BIT_RATE        = 1000,
  parameter int unsigned MIN_OCCUPANCY   = 50
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               enable,
  input  logic [COUNT_W-1:0] f0_value,
  input  logic [COUNT_W-1:0] f1_value,
  output logic               analyzer_enable,
  output logic               analyzer_clear,
  output logic               bit_data,
  output logic               bit_error,
  output logic               bit_valid,
  input  logic               bit_ready,
  output logic               overrun
);

  localparam logic [COUNT_W-1:0] WINDOW_TICKS =
    window_ticks(64'(CLOCK_FREQUENCY), 64'(BIT_RATE));
  localparam logic [COUNT_W-1:0] THRESH =
    occupancy_threshold(64'(WINDOW_TICKS), 64'(MIN_OCCUPANCY));

  fsk_state_t         state_reg;
  fsk_state_t         state_next;
  logic               window_end;
  logic               capture_now;
  logic               flush_pulse_reg;
  logic [COUNT_W-1:0] f0_q;
  logic [COUNT_W-1:0] f1_q;
  logic               dec_bit;
  logic               dec_err;
  logic               load;
  logic               consume;

  fsk_window_timer #(
    .WINDOW_TICKS(WINDOW_TICKS)
  ) u_timer (
    .clock     (clock),
    .clear     (clear),
    .enable    (enable),
    .run       (state_reg != IDLE),
    .window_end(window_end)
  );

  assign capture_now = (state_reg == RUN) & window_end;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // CAPTURE and FLUSH advance regardless of enable so a started window end always completes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (window_end) state_next = CAPTURE;
      CAPTURE: state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      f0_q            <= '0;
      f1_q            <= '0;
      flush_pulse_reg <= 1'b0;
      analyzer_enable <= 1'b0;
    end else begin
      if (capture_now) begin
        f0_q <= f0_value;
        f1_q <= f1_value;
      end
      flush_pulse_reg <= capture_now;
      analyzer_enable <= enable;
    end
  end

  // flush_pulse_reg is a flop, so this gate cannot glitch the analyzer clear.
  assign analyzer_clear = clear & ~flush_pulse_reg;

  always_comb begin
    dec_bit = 1'b0;
    dec_err = 1'b1;
    if ((f1_q > f0_q) && (f1_q >= THRESH)) begin
      dec_bit = 1'b1;
      dec_err = 1'b0;
    end else if ((f0_q > f1_q) && (f0_q >= THRESH)) begin
      dec_err = 1'b0;
    end
  end

  // The decision enters the buffer on the edge leaving CAPTURE, so it is visible in FLUSH.
  assign load    = (state_reg == CAPTURE);
  assign consume = bit_valid & bit_ready;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bit_data  <= 1'b0;
      bit_error <= 1'b0;
      bit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      if (!bit_valid || consume) begin
        bit_data  <= dec_bit;
        bit_error <= dec_err;
        bit_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (consume) begin
      bit_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsk_bit_decider.sv
// Scoreboard bench for fsk_bit_decider using a short 20-tick window (threshold 10).
// Expected bits are queued when a window's counts are driven and popped when consumed.
module tb_fsk_bit_decider;

  localparam int unsigned CLK_HZ = 20000;
  localparam int unsigned RATE   = 1000;
  localparam int unsigned OCC    = 50;
  localparam int          W      = 20;
  localparam int          PAUSE  = 30;

  typedef struct packed {
    logic [31:0] f0;
    logic [31:0] f1;
    logic        b;
    logic        e;
  } win_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        enable;
  logic        bit_ready;
  logic [31:0] f0_value;
  logic [31:0] f1_value;
  logic        analyzer_enable;
  logic        analyzer_clear;
  logic        bit_data;
  logic        bit_error;
  logic        bit_valid;
  logic        overrun;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  sb_q[$];
  win_t        basic[8];

  always #5 clock = ~clock;

  fsk_bit_decider #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BIT_RATE       (RATE),
    .MIN_OCCUPANCY  (OCC)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .enable         (enable),
    .f0_value       (f0_value),
    .f1_value       (f1_value),
    .analyzer_enable(analyzer_enable),
    .analyzer_clear (analyzer_clear),
    .bit_data       (bit_data),
    .bit_error      (bit_error),
    .bit_valid      (bit_valid),
    .bit_ready      (bit_ready),
    .overrun        (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (clear === 1'b1 && bit_valid === 1'b1 && bit_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [1:0] exp_v;
        exp_v = sb_q.pop_front();
        $display("[%0t] bit consumed: data=%0d error=%0d (expected %0d/%0d)",
                 $time, bit_data, bit_error, exp_v[1], exp_v[0]);
        check("bit_data", 32'(bit_data), 32'(exp_v[1]));
        check("bit_error", 32'(bit_error), 32'(exp_v[0]));
      end
    end
  end

  // Entered during reset; leaves the bench at T+1 of the first window.
  task automatic start_run(input logic [31:0] f0, input logic [31:0] f1, input logic b, input logic e);
    f0_value  = f0;
    f1_value  = f1;
    sb_q.push_back({b, e});
    bit_ready = 1'b1;
    clear     = 1'b1;
    enable    = 1'b1;
    check("aen_cycle0", 32'(analyzer_enable), 32'd0);
    tick();
    check("aen_cycle1", 32'(analyzer_enable), 32'd1);
    repeat (W - 1) tick();
    check("aclr_first_t", 32'(analyzer_clear), 32'd1);
    check("valid_first_t", 32'(bit_valid), 32'd0);
    tick();
    check("aclr_first_t1", 32'(analyzer_clear), 32'd0);
    check("valid_first_t1", 32'(bit_valid), 32'd0);
  endtask

  // Entered at T+1 of the previous window; leaves at T+1 of this one.
  task automatic do_window(input logic [31:0] f0, input logic [31:0] f1, input logic b,
                           input logic e, input bit push, input bit exp_ovr, input bit rdy_after);
    f0_value = f0;
    f1_value = f1;
    if (push) sb_q.push_back({b, e});
    tick();
    check("valid_t2", 32'(bit_valid), 32'd1);
    check("aclr_t2", 32'(analyzer_clear), 32'd1);
    check("overrun_t2", 32'(overrun), 32'(exp_ovr));
    bit_ready = rdy_after;
    repeat (W - 2) tick();
    check("aclr_t", 32'(analyzer_clear), 32'd1);
    tick();
    check("aclr_t1", 32'(analyzer_clear), 32'd0);
  endtask

  initial begin
    basic = '{
      '{32'd1,          32'd9,          1'b0, 1'b1},
      '{32'd12,         32'd12,         1'b0, 1'b1},
      '{32'd10,         32'd0,          1'b0, 1'b0},
      '{32'd0,          32'd10,         1'b1, 1'b0},
      '{32'd9,          32'd3,          1'b0, 1'b1},
      '{32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b0},
      '{32'h7FFF_FFFF,  32'h8000_0000,  1'b1, 1'b0},
      '{32'd20,         32'd19,         1'b0, 1'b0}
    };
    clear     = 1'b0;
    enable    = 1'b0;
    bit_ready = 1'b0;
    f0_value  = '0;
    f1_value  = '0;
    repeat (3) tick();
    check("rst_aen", 32'(analyzer_enable), 32'd0);
    check("rst_aclr", 32'(analyzer_clear), 32'd0);
    check("rst_data", 32'(bit_data), 32'd0);
    check("rst_error", 32'(bit_error), 32'd0);
    check("rst_valid", 32'(bit_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Tone 1 wins, then weak / tied / exact-threshold / unsigned-range windows
    start_run(32'd3, 32'd40000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_window(basic[i].f0, basic[i].f1, basic[i].b, basic[i].e, 1'b1, 1'b0, 1'b1);
    end

    // Consume and load on the same edge
    do_window(32'd5, 32'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    do_window(32'd15, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bit_ready = 1'b1;
    do_window(32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Backpressure over three windows
    do_window(32'd0, 32'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    do_window(32'd15, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_window(32'd15, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("held_data", 32'(bit_data), 32'd1);
    check("held_valid", 32'(bit_valid), 32'd1);
    do_window(32'd3, 32'd30, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    do_window(32'd30, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Enable pause mid-window
    f0_value = 32'd2;
    f1_value = 32'd17;
    sb_q.push_back(2'b10);
    tick();
    check("pause_prev_valid", 32'(bit_valid), 32'd1);
    repeat (4) tick();
    enable = 1'b0;
    check("pause_aen_before", 32'(analyzer_enable), 32'd1);
    tick();
    check("pause_aen_low", 32'(analyzer_enable), 32'd0);
    repeat (PAUSE - 1) tick();
    check("pause_aen_end", 32'(analyzer_enable), 32'd0);
    check("pause_valid", 32'(bit_valid), 32'd0);
    check("pause_aclr", 32'(analyzer_clear), 32'd1);
    enable = 1'b1;
    tick();
    check("pause_aen_back", 32'(analyzer_enable), 32'd1);
    repeat (W - 7) tick();
    check("pause_aclr_t", 32'(analyzer_clear), 32'd1);
    check("pause_valid_t", 32'(bit_valid), 32'd0);
    tick();
    check("pause_aclr_t1", 32'(analyzer_clear), 32'd0);
    do_window(32'd25, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset mid-window with a bit held and overrun set
    bit_ready = 1'b0;
    repeat (5) tick();
    check("prerst_valid", 32'(bit_valid), 32'd1);
    check("prerst_overrun", 32'(overrun), 32'd1);
    clear = 1'b0;
    #1;
    check("midrst_valid", 32'(bit_valid), 32'd0);
    check("midrst_data", 32'(bit_data), 32'd0);
    check("midrst_error", 32'(bit_error), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_aclr", 32'(analyzer_clear), 32'd0);
    check("midrst_aen", 32'(analyzer_enable), 32'd0);
    sb_q.delete();
    repeat (2) tick();
    start_run(32'd8, 32'd11, 1'b1, 1'b0);
    do_window(32'd11, 32'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    do_window(32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsk_bit_decider.md
# fsk_bit_decider

Downstream stage of the FSK frequency analyzer. It slices time into fixed bit windows and, at each window end, samples the analyzer's accumulated tone-0 and tone-1 tick counts. It decides the received bit, issues a one-cycle clear to the analyzer so the next window starts from zero, and presents the bit on a valid/ready output with a one-entry buffer.

## Interface
- `CLOCK_FREQUENCY`, 50000000, system clock in Hz.
- `BIT_RATE`, 1000, bits per second; `WINDOW_TICKS = CLOCK_FREQUENCY / BIT_RATE` (integer division, must be ≥ 4).
- `MIN_OCCUPANCY`, 50, percent of `WINDOW_TICKS` the winning tone must reach.
- `clock`  in  1  sole clock, rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run window timing; low pauses everything.
- `f0_value`  in  32  accumulated tone-0 ticks from the analyzer.
- `f1_value`  in  32  accumulated tone-1 ticks from the analyzer.
- `analyzer_enable`  out  1  drives the analyzer `enable`.
- `analyzer_clear`  out  1  drives the analyzer `clear` (active low).
- `bit_data`  out  1  decided bit.
- `bit_error`  out  1  qualifies `bit_data`: no valid tone in the window.
- `bit_valid`  out  1  output buffer holds a bit.
- `bit_ready`  in  1  consumer accepts when `bit_valid & bit_ready`.
- `overrun`  out  1  sticky: a decision was dropped.

## Operation
- **States:** IDLE, RUN, CAPTURE, FLUSH.
- **IDLE** (after reset):
  - `window_cnt` = 0.
  - Go to RUN on the first cycle with `enable` = 1.
- **RUN:**
  - `window_cnt` increments each enabled cycle.
  - At `window_cnt == WINDOW_TICKS-1`, latch `f0_value` and `f1_value` into `f0_q` and `f1_q`, then go to CAPTURE.
- **CAPTURE** (one cycle):
  - `window_cnt` = 0, counting restarts.
  - Drive the registered flush pulse.
  - Compute the decision from `f0_q` and `f1_q`; go to FLUSH.
- **FLUSH** (one cycle):
  - Load the decision into the output buffer; go to RUN.
  - Window timer keeps counting in CAPTURE and FLUSH, so the window period is exactly `WINDOW_TICKS` enabled cycles.
- **Decision:**
  - `THRESH = (WINDOW_TICKS * MIN_OCCUPANCY) / 100`, computed in 64 bits, truncated to 32.
  - `f1_q > f0_q` and `f1_q ≥ THRESH` → bit 1, error 0.
  - `f0_q > f1_q` and `f0_q ≥ THRESH` → bit 0, error 0.
  - Otherwise (tie, or winner below threshold) → bit 0, error 1.
  - All comparisons are unsigned 32-bit.
- **Output buffer:**
  - Load while empty: `bit_valid` ← 1.
  - Load while full and not consumed the same cycle: drop the new decision, keep the old one, set `overrun` (cleared only by `clear`).
  - Consume and load in the same cycle: the new decision replaces the old one, no overrun.
- **`analyzer_enable`** = `enable` registered, so it is 0 in reset and IDLE.
- **`analyzer_clear`** = `clear` AND NOT `flush_pulse`. It is the only combinational output path, and it is glitch-free because `flush_pulse` is a flop.
- **`enable` low:**
  - `window_cnt` and state hold.
  - A pending CAPTURE or FLUSH completes. Output handshake still operates.

## Timing
- **Reset values:**
  - `analyzer_enable` = 0.
  - `analyzer_clear` = 0, combinational from `clear`.
  - `bit_data`, `bit_error`, `bit_valid`, `overrun` = 0.
  - State IDLE, counters 0.
- **Window end sequence,** with T = the cycle where `window_cnt == WINDOW_TICKS-1`:
  - Counts are latched on the rising edge ending T.
  - `analyzer_clear` is low during T+1 only.
  - `bit_valid` rises at T+2.
- **Reset mid-operation:**
  - Immediate asynchronous return to reset values.
  - A partially accumulated window is discarded.
  - The analyzer is cleared concurrently through `analyzer_clear`.
- **Wrap:** `window_cnt` returns to 0 and never exceeds `WINDOW_TICKS-1`.

## Structure
- Package `fsk_pkg`:
  - state enum (IDLE, RUN, CAPTURE, FLUSH);
  - function `window_ticks(clock_hz, bit_rate)`;
  - function `occupancy_threshold(ticks, percent)`;
  - shared 32-bit count width constant.
- One natural sub-module, `fsk_window_timer`: `window_cnt`, the terminal-count strobe and the enable hold. Decision logic and output buffer stay in the top module.

## Test plan
All scenarios use `CLOCK_FREQUENCY` = 50000000, `BIT_RATE` = 1000, `MIN_OCCUPANCY` = 50, giving `WINDOW_TICKS` = 50000 and `THRESH` = 25000.
- Reset while running:
  - stimulus: `clear` low mid-window;
  - response: all outputs at reset values immediately; first `bit_valid` exactly 50002 enabled cycles after `clear` rises and `enable` is 1.
- Tone 1 wins:
  - stimulus: `f1_value` = 40000, `f0_value` = 3000 at T;
  - response: `analyzer_clear` low at T+1 only; `bit_data` = 1, `bit_error` = 0, `bit_valid` = 1 at T+2.
- Weak or tied tones:
  - stimulus: 24999 vs 100 → `bit_error` = 1, `bit_data` = 0;
  - stimulus: 30000 vs 30000 → `bit_error` = 1;
  - stimulus: exactly 25000 vs 0 → valid bit.
- Backpressure:
  - stimulus: `bit_ready` = 0 for three windows;
  - response: first bit held, `overrun` = 1 at the second window's T+2 and stays 1.
- Simultaneous consume and load:
  - stimulus: `bit_ready` = 1 exactly at T+1 of the next window;
  - response: new bit replaces old, `overrun` stays 0.
- Enable pause:
  - stimulus: `enable` low for 1000 cycles mid-window;
  - response: decision arrives 1000 cycles late; `analyzer_enable` low for the paused span, delayed one cycle.
